bolme_birimi: RTL and testbench

- Multi-cycle integer divider for the RV32M DIV/DIVU/REM/REMU instructions.
- Sits in the execute stage beside the single-cycle ALU; the execute stage stalls the pipeline while `mesgul_o` is high.
- Uses a radix-2 restoring algorithm on magnitudes, then applies a sign fix-up step.
- Produces RISC-V-compliant results for division by zero and for signed overflow.

---
 rtl/bolme_birimi_if.sv | 57 +++++
 rtl/bolme_birimi.sv | 235 +++++++++++++++++++++++
 tb/tb_bolme_birimi.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bolme_birimi_if.sv
`default_nettype none
// ============================================================================
// Module      : bolme_birimi_if
// Description : Request/response bundle between the execute stage and the
//               multi-cycle RV32M divider (bolme_birimi).
//
//   Signals
//     basla_i    1  start request, honoured only while mesgul_o = 0
//     kontrol_i  2  operation: 00 DIV, 01 DIVU, 10 REM, 11 REMU
//     bolunen_i  32 dividend
//     bolen_i    32 divisor
//     iptal_i    1  synchronous flush (mispredict / trap)
//     sonuc_o    32 result, held until the next accepted start
//     gecerli_o  1  one-cycle pulse marking sonuc_o valid
//     mesgul_o   1  operation in progress
//
//   Modports
//     master : execute stage (drives the request, observes the response)
//     slave  : divider       (observes the request, drives the response)
//
// Revision    : 1.0 - initial release
// ============================================================================
interface bolme_birimi_if;

    logic        basla_i;
    logic [1:0]  kontrol_i;
    logic [31:0] bolunen_i;
    logic [31:0] bolen_i;
    logic        iptal_i;
    logic [31:0] sonuc_o;
    logic        gecerli_o;
    logic        mesgul_o;

    modport master (
        output basla_i,
        output kontrol_i,
        output bolunen_i,
        output bolen_i,
        output iptal_i,
        input  sonuc_o,
        input  gecerli_o,
        input  mesgul_o
    );

    modport slave (
        input  basla_i,
        input  kontrol_i,
        input  bolunen_i,
        input  bolen_i,
        input  iptal_i,
        output sonuc_o,
        output gecerli_o,
        output mesgul_o
    );

endinterface : bolme_birimi_if
`default_nettype wire

// File: rtl/bolme_birimi.sv
`default_nettype none
// ============================================================================
// Module      : bolme_birimi
// Description : Multi-cycle 32-bit integer divider for RV32M DIV/DIVU/REM/REMU.
//               Radix-2 restoring division on operand magnitudes followed by a
//               sign fix-up step. Division by zero and the signed overflow
//               case (0x80000000 / -1) fall out of the datapath naturally and
//               give the RISC-V mandated results.
//
//   Ports
//     clk_i  in  1   clock, rising edge
//     rst_i  in  1   asynchronous, active-high reset
//     bus    slave   bolme_birimi_if (basla_i, kontrol_i, bolunen_i, bolen_i,
//                    iptal_i -> sonuc_o, gecerli_o, mesgul_o)
//
//   Latency
//     Acceptance at edge k, result registered at edge k+33, gecerli_o high
//     for the cycle that follows. mesgul_o and gecerli_o are registered and
//     never high together.
//
//   Optional feature (macro BOLME_KISAYOL_EN)
//     When defined, a zero divisor or the signed overflow pair is detected
//     at acceptance and the iteration phase is skipped: the result is
//     registered at edge k+1. Results are identical either way.
//
// Revision    : 1.0 - initial release
// ============================================================================
module bolme_birimi (
    input  logic          clk_i,
    input  logic          rst_i,
    bolme_birimi_if.slave bus
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic [5:0]  c_SAYAC_YUK = 6'd32;        // iterations per op
    localparam logic [31:0] c_TUM_BIR   = 32'hFFFF_FFFF;

    // State encoding (state 2'd3 is unreachable and recovers to BOS)
    typedef enum logic [1:0] {
        BOS     = 2'd0,   // idle, waiting for a start
        HESAPLA = 2'd1,   // one restoring iteration per cycle
        DUZELT  = 2'd2    // sign fix-up and result select
    } durum_t;

    // ------------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------------
    durum_t      r_durum;
    logic [5:0]  r_sayac;          // remaining iterations
    logic [31:0] r_kalan;          // partial remainder
    logic [31:0] r_bolum;          // dividend shifting out / quotient in
    logic [31:0] r_bolen;          // divisor magnitude
    logic        r_isaretli;       // latched: signed operation
    logic        r_kalan_sec;      // latched: REM/REMU selects remainder
    logic        r_bolunen_neg;    // dividend was negative (signed ops only)
    logic        r_bolen_neg;      // divisor was negative (signed ops only)

    // Registered outputs
    logic [31:0] r_sonuc;
    logic        r_gecerli;
    logic        r_mesgul;

    // ------------------------------------------------------------------------
    // Acceptance-side combinational logic
    // ------------------------------------------------------------------------
    logic        w_isaretli;
    logic        w_bolunen_neg;
    logic        w_bolen_neg;
    logic [31:0] w_bolunen_mut;
    logic [31:0] w_bolen_mut;
    logic        w_kabul;
    logic        w_kisayol;

    // kontrol_i[0] = 0 marks the signed flavours (DIV, REM)
    assign w_isaretli    = ~bus.kontrol_i[0];
    assign w_bolunen_neg = w_isaretli & bus.bolunen_i[31];
    assign w_bolen_neg   = w_isaretli & bus.bolen_i[31];

    // Magnitudes. 0x80000000 negates to itself, which read as unsigned is
    // exactly its magnitude, so no extra bit is needed.
    assign w_bolunen_mut = w_bolunen_neg ? (32'd0 - bus.bolunen_i) : bus.bolunen_i;
    assign w_bolen_mut   = w_bolen_neg   ? (32'd0 - bus.bolen_i)   : bus.bolen_i;

    // A start is taken only from idle; mesgul_o is high in every other state
    assign w_kabul = bus.basla_i & (r_durum == BOS);

`ifdef BOLME_KISAYOL_EN
    logic w_sifir_bolen;
    logic w_tasma;

    assign w_sifir_bolen = (bus.bolen_i == 32'd0);
    assign w_tasma       = w_isaretli
                         & (bus.bolunen_i == 32'h8000_0000)
                         & (bus.bolen_i   == c_TUM_BIR);
    assign w_kisayol     = w_sifir_bolen | w_tasma;
`else
    assign w_kisayol     = 1'b0;
`endif

    // ------------------------------------------------------------------------
    // Iteration datapath
    // ------------------------------------------------------------------------
    // {remainder, quotient} shifted left by one: the dividend MSB still held
    // in r_bolum[31] enters the remainder. The trial subtraction is 33 bits
    // wide because the shifted remainder can reach 2*divisor - 1.
    logic [32:0] w_kaydir;
    logic [32:0] w_fark;
    logic        w_fark_neg;

    assign w_kaydir   = {r_kalan, r_bolum[31]};
    assign w_fark     = w_kaydir - {1'b0, r_bolen};
    assign w_fark_neg = w_fark[32];

    // ------------------------------------------------------------------------
    // Fix-up datapath
    // ------------------------------------------------------------------------
    // The quotient keeps its all-ones pattern on a zero divisor, so the sign
    // flip is suppressed there. The remainder follows the dividend sign;
    // on a zero divisor it is |dividend| and flipping restores the dividend.
    logic        w_bolum_cevir;
    logic        w_kalan_cevir;
    logic [31:0] w_bolum_son;
    logic [31:0] w_kalan_son;

    assign w_bolum_cevir = r_isaretli
                         & (r_bolunen_neg ^ r_bolen_neg)
                         & (r_bolen != 32'd0);
    assign w_kalan_cevir = r_isaretli & r_bolunen_neg;
    assign w_bolum_son   = w_bolum_cevir ? (32'd0 - r_bolum) : r_bolum;
    assign w_kalan_son   = w_kalan_cevir ? (32'd0 - r_kalan) : r_kalan;

    // ------------------------------------------------------------------------
    // Control FSM with registered outputs
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_durum       <= BOS;
            r_sayac       <= 6'd0;
            r_kalan       <= 32'd0;
            r_bolum       <= 32'd0;
            r_bolen       <= 32'd0;
            r_isaretli    <= 1'b0;
            r_kalan_sec   <= 1'b0;
            r_bolunen_neg <= 1'b0;
            r_bolen_neg   <= 1'b0;
            r_sonuc       <= 32'd0;
            r_gecerli     <= 1'b0;
            r_mesgul      <= 1'b0;
        end else begin
            // The valid flag is a single-cycle pulse
            r_gecerli <= 1'b0;

            if (bus.iptal_i) begin
                // Flush wins over everything, including a simultaneous start.
                // The previous result stays visible on sonuc_o.
                r_durum  <= BOS;
                r_sayac  <= 6'd0;
                r_mesgul <= 1'b0;
            end else begin
                case (r_durum)
                    BOS: begin
                        if (w_kabul) begin
                            r_isaretli    <= w_isaretli;
                            r_kalan_sec   <= bus.kontrol_i[1];
                            r_bolunen_neg <= w_bolunen_neg;
                            r_bolen_neg   <= w_bolen_neg;
                            r_bolen       <= w_bolen_mut;
                            r_mesgul      <= 1'b1;
                            if (w_kisayol) begin
                                // Preload what the iterations would have left
                                // behind and go straight to the fix-up:
                                //   x/0      -> quotient all ones, rem |x|
                                //   MIN/-1   -> quotient 0x80000000, rem 0
                                // Both operands are negative in the overflow
                                // case, so the fix-up leaves the quotient as is.
                                if (bus.bolen_i == 32'd0) begin
                                    r_bolum <= c_TUM_BIR;
                                    r_kalan <= w_bolunen_mut;
                                end else begin
                                    r_bolum <= 32'h8000_0000;
                                    r_kalan <= 32'd0;
                                end
                                r_sayac <= 6'd0;
                                r_durum <= DUZELT;
                            end else begin
                                r_bolum <= w_bolunen_mut;
                                r_kalan <= 32'd0;
                                r_sayac <= c_SAYAC_YUK;
                                r_durum <= HESAPLA;
                            end
                        end
                    end

                    HESAPLA: begin
                        if (!w_fark_neg) begin
                            r_kalan <= w_fark[31:0];
                            r_bolum <= {r_bolum[30:0], 1'b1};
                        end else begin
                            r_kalan <= w_kaydir[31:0];
                            r_bolum <= {r_bolum[30:0], 1'b0};
                        end
                        r_sayac <= r_sayac - 6'd1;
                        // Counter reaching zero on this edge ends iterating
                        if (r_sayac == 6'd1) begin
                            r_durum <= DUZELT;
                        end
                    end

                    DUZELT: begin
                        r_sonuc   <= r_kalan_sec ? w_kalan_son : w_bolum_son;
                        r_gecerli <= 1'b1;
                        r_mesgul  <= 1'b0;
                        r_durum   <= BOS;
                    end

                    default: begin
                        r_durum  <= BOS;
                        r_mesgul <= 1'b0;
                    end
                endcase
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign bus.sonuc_o   = r_sonuc;
    assign bus.gecerli_o = r_gecerli;
    assign bus.mesgul_o  = r_mesgul;

endmodule : bolme_birimi
`default_nettype wire

// File: tb/tb_bolme_birimi.sv
`default_nettype none
// ============================================================================
// Module      : tb_bolme_birimi
// Description : Self-checking bench for bolme_birimi. A driver issues
//               directed and random operations and pushes the expected
//               result and arrival cycle into a queue; an independent
//               monitor pops and compares on every gecerli_o pulse.
//               Expected values come from RISC-V division rules written with
//               plain integer arithmetic. Honours BOLME_KISAYOL_EN for the
//               expected latency.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bolme_birimi;

    localparam logic [1:0] c_DIV  = 2'b00;
    localparam logic [1:0] c_DIVU = 2'b01;
    localparam logic [1:0] c_REM  = 2'b10;
    localparam logic [1:0] c_REMU = 2'b11;

    logic clk_i = 1'b0;
    logic rst_i;

    bolme_birimi_if bus();

    bolme_birimi u_dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] sonuc;
        int          cyc;
    } beklenen_t;

    beklenen_t   sb_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] son_sonuc = 32'd0;   // last expected result delivered

    // ------------------------------------------------------------------------
    // Reference model: RISC-V M-extension division semantics
    // ------------------------------------------------------------------------
    function automatic logic [31:0] referans(input logic [1:0] op,
                                             input logic [31:0] a,
                                             input logic [31:0] b);
        int   sa;
        int   sb;
        logic tasma;
        sa    = a;
        sb    = b;
        tasma = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (op)
            c_DIV: begin
                if (b == 32'd0)  return 32'hFFFF_FFFF;
                else if (tasma)  return 32'h8000_0000;
                else             return 32'(sa / sb);
            end
            c_DIVU: begin
                if (b == 32'd0)  return 32'hFFFF_FFFF;
                else             return a / b;
            end
            c_REM: begin
                if (b == 32'd0)  return a;
                else if (tasma)  return 32'd0;
                else             return 32'(sa % sb);
            end
            default: begin
                if (b == 32'd0)  return a;
                else             return a % b;
            end
        endcase
    endfunction

    function automatic int gecikme(input logic [1:0] op,
                                   input logic [31:0] a,
                                   input logic [31:0] b);
        bit kisa;
        kisa = (b == 32'd0) ||
               (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
`ifdef BOLME_KISAYOL_EN
        return kisa ? 1 : 33;
`else
        return (kisa && 1'b0) ? 1 : 33;
`endif
    endfunction

    task automatic kontrol(input string ad, input logic [31:0] gercek,
                           input logic [31:0] beklenen);
        checks++;
        if (gercek !== beklenen) begin
            errors++;
            $display("FAIL %s: got %h, required %h", ad, gercek, beklenen);
        end
    endtask

    // Called at a falling edge; returns at the falling edge after acceptance.
    task automatic gonder(input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input bit mesgulde_darbe);
        beklenen_t e;
        int        bekle;
        bekle = 0;
        while (bus.mesgul_o && bekle < 200) begin
            if (mesgulde_darbe) begin
                // Garbage starts while busy must be ignored
                bus.basla_i   = 1'($urandom_range(0, 1));
                bus.kontrol_i = 2'($urandom);
                bus.bolunen_i = $urandom;
                bus.bolen_i   = $urandom;
            end
            @(negedge clk_i);
            bekle++;
        end
        if (bekle >= 200) begin
            checks++;
            errors++;
            $display("FAIL busy_timeout: mesgul_o still 1 after %0d cycles, required 0", bekle);
        end
        bus.basla_i   = 1'b1;
        bus.kontrol_i = op;
        bus.bolunen_i = a;
        bus.bolen_i   = b;
        e.op    = op;
        e.a     = a;
        e.b     = b;
        e.sonuc = referans(op, a, b);
        e.cyc   = cyc + 1 + gecikme(op, a, b);
        sb_q.push_back(e);
        @(negedge clk_i);
        bus.basla_i = 1'b0;
    endtask

    task automatic bekle_bos(input int sinir);
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < sinir) begin
            @(negedge clk_i);
            n++;
        end
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: %0d results pending, required 0", sb_q.size());
        end
    endtask

    // ------------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------------
    initial begin
        beklenen_t e;
        forever begin
            @(negedge clk_i);
            if (bus.gecerli_o && bus.mesgul_o) begin
                checks++;
                errors++;
                $display("FAIL valid_busy_overlap: gecerli_o=1 mesgul_o=1, required not both");
            end
            if (bus.gecerli_o) begin
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_valid: got pulse with sonuc=%h at cycle %0d, required no pulse",
                             bus.sonuc_o, cyc);
                end else begin
                    e = sb_q.pop_front();
                    son_sonuc = e.sonuc;
                    if (bus.sonuc_o !== e.sonuc || cyc != e.cyc) begin
                        errors++;
                        $display("FAIL result op=%0d a=%h b=%h: got %h at cycle %0d, required %h at cycle %0d",
                                 e.op, e.a, e.b, bus.sonuc_o, cyc, e.sonuc, e.cyc);
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------------
    initial begin
        int          k;
        int          sel;
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;

        rst_i         = 1'b1;
        bus.basla_i   = 1'b0;
        bus.kontrol_i = 2'b00;
        bus.bolunen_i = 32'd0;
        bus.bolen_i   = 32'd0;
        bus.iptal_i   = 1'b0;
        repeat (3) @(negedge clk_i);
        kontrol("reset_sonuc",   bus.sonuc_o,   32'd0);
        kontrol("reset_gecerli", 32'(bus.gecerli_o), 32'd0);
        kontrol("reset_mesgul",  32'(bus.mesgul_o),  32'd0);
        rst_i = 1'b0;
        @(negedge clk_i);

        // Directed cases
        gonder(c_DIVU, 32'd100,         32'd7,           1'b0);
        gonder(c_REMU, 32'd100,         32'd7,           1'b0);
        gonder(c_DIV,  32'hFFFF_FFF9,   32'd2,           1'b0);
        gonder(c_REM,  32'hFFFF_FFF9,   32'd2,           1'b0);
        gonder(c_REM,  32'd7,           32'hFFFF_FFFE,   1'b0);
        gonder(c_DIV,  32'h8000_0005,   32'd0,           1'b0);
        gonder(c_DIVU, 32'h8000_0005,   32'd0,           1'b0);
        gonder(c_REM,  32'h8000_0005,   32'd0,           1'b0);
        gonder(c_REMU, 32'h8000_0005,   32'd0,           1'b0);
        gonder(c_DIV,  32'h8000_0000,   32'hFFFF_FFFF,   1'b0);
        gonder(c_REM,  32'h8000_0000,   32'hFFFF_FFFF,   1'b0);
        gonder(c_DIVU, 32'd12345,       32'd1,           1'b0);
        bekle_bos(100);

        // Flush at iteration 10, then DIVU 9/3 in the following cycle
        gonder(c_DIVU, 32'hDEAD_BEEF, 32'd3, 1'b0);
        k = cyc;
        while (cyc < k + 9) @(negedge clk_i);
        bus.iptal_i = 1'b1;
        void'(sb_q.pop_back());
        @(negedge clk_i);
        bus.iptal_i = 1'b0;
        kontrol("iptal_mesgul", 32'(bus.mesgul_o), 32'd0);
        kontrol("iptal_sonuc_held", bus.sonuc_o, son_sonuc);
        gonder(c_DIVU, 32'd9, 32'd3, 1'b0);
        bekle_bos(100);

        // Flush has priority over a simultaneous start in idle
        bus.basla_i   = 1'b1;
        bus.iptal_i   = 1'b1;
        bus.kontrol_i = c_DIVU;
        bus.bolunen_i = 32'd50;
        bus.bolen_i   = 32'd5;
        @(negedge clk_i);
        bus.basla_i = 1'b0;
        bus.iptal_i = 1'b0;
        kontrol("iptal_oncelik_mesgul", 32'(bus.mesgul_o), 32'd0);
        repeat (40) @(negedge clk_i);

        // Asynchronous reset in the middle of an iteration
        gonder(c_DIV, 32'h1234_5678, 32'd7, 1'b0);
        repeat (5) @(negedge clk_i);
        #2;
        rst_i = 1'b1;
        #1;
        kontrol("async_reset_sonuc",   bus.sonuc_o,   32'd0);
        kontrol("async_reset_gecerli", 32'(bus.gecerli_o), 32'd0);
        kontrol("async_reset_mesgul",  32'(bus.mesgul_o),  32'd0);
        sb_q.delete();
        @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);
        gonder(c_REM, 32'hFFFF_FF00, 32'd7, 1'b0);
        bekle_bos(100);

        // Random operations, back-to-back, with garbage starts while busy
        for (int i = 0; i < 150; i++) begin
            op  = 2'($urandom);
            a   = $urandom;
            b   = $urandom;
            sel = $urandom_range(0, 15);
            if (sel == 0)       b = 32'd0;
            else if (sel == 1) begin
                a = 32'h8000_0000;
                b = 32'hFFFF_FFFF;
            end
            else if (sel < 6)   b = 32'($urandom_range(1, 20));
            else if (sel < 8)   b = 32'd0 - 32'($urandom_range(1, 20));
            else if (sel == 8)  a = 32'($urandom_range(0, 100));
            gonder(op, a, b, 1'b1);
        end
        bus.basla_i = 1'b0;
        bekle_bos(200);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_bolme_birimi
`default_nettype wire
